// File: rtl/uart_txd.sv
`default_nettype none
// ============================================================================
// Module      : uart_txd
// Description : UART transmit path. Accepts one byte on a load strobe and
//               serialises it onto txd as start(0), 8 data bits LSB first,
//               [optional even parity], stop(1). Bit timing comes from an
//               internal 16-bit baud counter running off clk.
// Ports       : clk       - system clock, all logic on posedge
//               reset     - synchronous, active-low reset
//               load      - transmit request, sampled only while idle
//               data_in   - byte to send, captured on the accepting edge
//               txd       - serial line, idle-high
//               busy      - high while a frame is on the line
//               done      - one-cycle pulse after the last stop-bit cycle
//               frame_out - transmit shift register contents (debug tap)
// Options     : define UART_TXD_PARITY_EN to add an even-parity bit
//               (frame and frame_out widen to 11 bits).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_txd #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
`ifdef UART_TXD_PARITY_EN
    localparam int c_FRAME_W   = 11,
    localparam int c_BIT_W     = 4
`else
    localparam int c_FRAME_W   = 10,
    localparam int c_BIT_W     = 3
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 txd,
    output logic                 busy,
    output logic                 done,
    output logic [c_FRAME_W-1:0] frame_out
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
`ifdef UART_TXD_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    localparam logic [15:0]        c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

    logic [2:0]           r_state;
    logic [15:0]          r_baud;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_FRAME_W-1:0] r_shreg;
    logic                 r_busy;
    logic                 r_done;

    logic [2:0]           w_state_nxt;
    logic [15:0]          w_baud_nxt;
    logic [c_BIT_W-1:0]   w_bit_nxt;
    logic [c_FRAME_W-1:0] w_shreg_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_bit_end;
    logic [c_FRAME_W-1:0] w_frame_load;

    assign w_bit_end = (r_baud == c_BAUD_LAST);

`ifdef UART_TXD_PARITY_EN
    assign w_frame_load = {1'b1, ^data_in, data_in, 1'b0};
`else
    assign w_frame_load = {1'b1, data_in, 1'b0};
`endif

    // State register. The shift register resets to all ones so txd sits
    // idle-high immediately, including when a frame is abandoned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shreg   <= w_shreg_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic. Every non-idle state shares the same bit-period
    // timing: count to CLKS_PER_BIT-1, then shift one bit out (ones fill
    // from the top, so a finished frame leaves the register all ones).
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        if (r_state != c_S_IDLE) begin
            if (w_bit_end) begin
                w_baud_nxt  = '0;
                w_shreg_nxt = {1'b1, r_shreg[c_FRAME_W-1:1]};
            end else begin
                w_baud_nxt  = r_baud + 16'd1;
            end
        end

        case (r_state)
            c_S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (load) begin
                    w_state_nxt = c_S_START;
                    w_baud_nxt  = '0;
                    w_shreg_nxt = w_frame_load;
                    w_busy_nxt  = 1'b1;
                end
            end
            c_S_START: begin
                if (w_bit_end) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_bit_end) begin
                    w_bit_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_TXD_PARITY_EN
                        w_state_nxt = c_S_PARITY;
`else
                        w_state_nxt = c_S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TXD_PARITY_EN
            c_S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_S_STOP;
                end
            end
`endif
            c_S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = c_S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_busy_nxt  = 1'b0;
                w_shreg_nxt = '1;
            end
        endcase
    end

    assign txd       = r_shreg[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_out = r_shreg;

endmodule
`default_nettype wire

// File: tb/tb_uart_txd.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_txd
// Description : Scoreboard bench for uart_txd. Stimulus pushes expected
//               frames (byte, parity, start cycle); a line monitor rebuilds
//               frames from txd and compares when each frame completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_txd;

    localparam int C = 4;
`ifdef UART_TXD_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam logic [NB-1:0] c_ONES = '1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          txd;
    logic          busy;
    logic          done;
    logic [NB-1:0] frame_out;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    uart_txd #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .txd       (txd),
        .busy      (busy),
        .done      (done),
        .frame_out (frame_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit            m_in_frame = 0;
    bit            m_pending = 0;
    bit            m_stable_err = 0;
    bit            m_busy_err = 0;
    int            m_cnt = 0;
    int            m_start = 0;
    logic [NB-1:0] m_bits = '0;
    logic [NB-1:0] m_ef;
    exp_t          m_e;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                check("rst_txd", txd, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_frame_out", frame_out, c_ONES);
                m_in_frame = 0;
                m_pending  = 0;
            end else begin
                check("done", done, m_pending);
                if (m_pending) begin
                    m_pending = 0;
                    check("done_busy", busy, 0);
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL extra_frame @cyc %0d: got frame %h, expected none", cyc, m_bits);
                    end else begin
                        m_e = sb_q.pop_front();
`ifdef UART_TXD_PARITY_EN
                        m_ef = {1'b1, m_e.par, m_e.data, 1'b0};
`else
                        m_ef = {1'b1, m_e.data, 1'b0};
`endif
                        check("frame_bits", m_bits, m_ef);
                        check("frame_start", m_start, m_e.start);
                        check("bit_stable", m_stable_err, 0);
                        check("frame_busy", m_busy_err, 0);
                    end
                end
                if (!m_in_frame && txd == 1'b0) begin
                    m_in_frame   = 1;
                    m_cnt        = 0;
                    m_start      = cyc;
                    m_stable_err = 0;
                    m_busy_err   = 0;
                end
                if (m_in_frame) begin
                    if (m_cnt % C == 0) m_bits[m_cnt / C] = txd;
                    else if (txd !== m_bits[m_cnt / C]) m_stable_err = 1;
                    if (busy !== 1'b1) m_busy_err = 1;
                    m_cnt++;
                    if (m_cnt == NB * C) begin
                        m_in_frame = 0;
                        m_pending  = 1;
                    end
                end else begin
                    check("idle_busy", busy, 0);
                    check("idle_frame_out", frame_out, c_ONES);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        exp_t e;
        @(negedge clk);
        load    = 1'b1;
        data_in = d;
        e.data = d; e.par = p; e.start = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin : driver
        exp_t e;
        int   n0;
        // reset then idle
        tick(3);
        reset = 1'b1;
        tick(20);

        // single frame
        send(8'hA5, 1'b0);
        tick(NB * C + 4);

        // load while busy is ignored
        send(8'h3C, 1'b0);
        tick(9);
        load = 1'b1; data_in = 8'hFF;
        tick(1);
        load = 1'b0;
        tick(NB * C + 4);

        // back-to-back with load held high
        @(negedge clk);
        load = 1'b1; data_in = 8'h01;
        n0 = cyc + 1;
        e.data = 8'h01; e.par = 1'b1; e.start = n0;
        sb_q.push_back(e);
        tick(1);
        data_in = 8'h80;
        e.data = 8'h80; e.par = 1'b1; e.start = n0 + NB * C + 1;
        sb_q.push_back(e);
        tick(NB * C + 2);
        load = 1'b0;
        tick(NB * C + 4);

        // reset during DATA bit 3: frame abandoned, not expected
        @(negedge clk);
        load = 1'b1; data_in = 8'hF0;
        tick(1);
        load = 1'b0;
        tick(17);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(5);
        send(8'h55, 1'b0);
        tick(NB * C + 4);

`ifdef UART_TXD_PARITY_EN
        send(8'h07, 1'b1);
        tick(NB * C + 4);
        send(8'h03, 1'b0);
        tick(NB * C + 4);
`endif

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
